// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM states, response
// codes and the register map of the control/status slave it talks to.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_RSP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] REG_CTRL    = 32'h0000_0000;
    localparam logic [31:0] REG_CONTROL = 32'h0000_0010;

    // States in which the master is stalled on the slave.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_WRITE) || (s == ST_WRESP) || (s == ST_RADDR) || (s == ST_RDATA);
    endfunction

endpackage

// File: rtl/axil_cmd_master_if.sv
// Command/response handshake plus the five AXI4-Lite channels of the master.
// The master modport is the view of axil_cmd_master itself.
interface axil_cmd_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_write;

    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_resp, rsp_write,
        input  rsp_ready,
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_resp, rsp_write,
        output rsp_ready,
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: one register command in, one AXI-Lite transaction out,
// one response back. Only a single command is ever outstanding.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    axil_cmd_master_if.master bus,
    output logic              busy,
    output logic              timeout
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             arvalid_q, arvalid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_resp_q, rsp_resp_d;
    logic             rsp_write_q, rsp_write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    wstrb_d     = bus.cmd_wstrb;
                    rsp_write_d = bus.cmd_write;
                    cnt_d       = '0;
                    if (bus.cmd_write) begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                // AW and W retire independently; leave once neither is pending.
                if (awvalid_q && bus.M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && bus.M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)        state_d   = ST_WRESP;
            end
            ST_WRESP: begin
                if (bus.M_AXI_BVALID) begin
                    rsp_resp_d = bus.M_AXI_BRESP;
                    rsp_data_d = '0;
                    state_d    = ST_RSP;
                end
            end
            ST_RADDR: begin
                if (bus.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (bus.M_AXI_RVALID) begin
                    rsp_data_d = bus.M_AXI_RDATA;
                    rsp_resp_d = bus.M_AXI_RRESP;
                    state_d    = ST_RSP;
                end
            end
            ST_RSP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout only flags a slow slave; the transfer keeps waiting since
        // withdrawing VALID would break the protocol.
        if (is_wait_state(state_q) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
        if ((TIMEOUT != 0) && is_wait_state(state_q) && (cnt_d == CNT_MAX)) timeout_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= RESP_OKAY;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    // Payload registers only change at command acceptance, so no reset needed.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    assign bus.cmd_ready     = (state_q == ST_IDLE);
    assign bus.rsp_valid     = (state_q == ST_RSP);
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.rsp_write     = rsp_write_q;

    assign bus.M_AXI_AWADDR  = addr_q;
    assign bus.M_AXI_AWPROT  = 3'b000;
    assign bus.M_AXI_AWVALID = awvalid_q;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = wstrb_q;
    assign bus.M_AXI_WVALID  = wvalid_q;
    assign bus.M_AXI_BREADY  = (state_q == ST_WRESP);
    assign bus.M_AXI_ARADDR  = addr_q;
    assign bus.M_AXI_ARPROT  = 3'b000;
    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.M_AXI_RREADY  = (state_q == ST_RDATA);

    assign busy    = (state_q != ST_IDLE);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed and randomized bench for axil_cmd_master against a behavioural
// AXI-Lite register slave and a command-level reference model.
module tb_axil_cmd_master;
    import axil_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic timeout;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_cmd_master_if bus ();

    axil_cmd_master #(.TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .timeout (timeout)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Slave register map rule: 16 words at 0x00-0x3C, word 0x3C rejects with
    // SLVERR, anything above 0x3F decodes to nothing.
    function automatic logic [1:0] slave_rule(input logic [31:0] a);
        if (a[31:6] != 26'd0) return RESP_DECERR;
        if (a[5:2] == 4'hF)   return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    // ---------------- behavioural slave ----------------
    logic [31:0] smem [16];
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int b_hs_count = 0, aw_only = 0, prot_err = 0;

    initial begin : slave
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit have_aw, have_w, b_arm, r_arm;
        bit hs_aw, hs_w, hs_b, hs_ar, hs_r, pv_aw, pv_w, pv_ar;
        logic [31:0] l_awaddr, l_wdata, l_araddr, s_awaddr, s_wdata, s_araddr;
        logic [3:0]  l_wstrb, s_wstrb;
        logic [1:0]  s_bresp, er;
        for (int i = 0; i < 16; i++) smem[i] = 32'h0;
        bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
        bus.M_AXI_BVALID  = 1'b0; bus.M_AXI_BRESP  = 2'b00;
        bus.M_AXI_RVALID  = 1'b0; bus.M_AXI_RRESP  = 2'b00; bus.M_AXI_RDATA = 32'h0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        {have_aw, have_w, b_arm, r_arm, hs_aw, hs_w, hs_b, hs_ar, hs_r, pv_aw, pv_w, pv_ar} = '0;
        {l_awaddr, l_wdata, l_araddr, s_awaddr, s_wdata, s_araddr} = '0;
        {l_wstrb, s_wstrb, s_bresp} = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
                bus.M_AXI_BVALID  = 1'b0; bus.M_AXI_RVALID = 1'b0;
                {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
                {have_aw, have_w, b_arm, r_arm, hs_aw, hs_w, hs_b, hs_ar, hs_r, pv_aw, pv_w, pv_ar} = '0;
                continue;
            end
            // VALID must not drop, nor payload move, before its handshake.
            if (pv_aw && !hs_aw && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR != l_awaddr)) prot_err++;
            if (pv_w && !hs_w && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA != l_wdata || bus.M_AXI_WSTRB != l_wstrb)) prot_err++;
            if (pv_ar && !hs_ar && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR != l_araddr)) prot_err++;
            // Handshakes that completed on the posedge just passed.
            if (hs_aw) begin have_aw = 1; s_awaddr = l_awaddr; aw_cnt = 0; end
            if (hs_w)  begin have_w = 1; s_wdata = l_wdata; s_wstrb = l_wstrb; w_cnt = 0; end
            if (hs_b)  begin bus.M_AXI_BVALID = 1'b0; b_hs_count++; end
            if (hs_ar) begin s_araddr = l_araddr; ar_cnt = 0; r_arm = 1; r_cnt = 0; end
            if (hs_r)  bus.M_AXI_RVALID = 1'b0;
            if (have_aw && have_w) begin
                s_bresp = slave_rule(s_awaddr);
                if (s_bresp == RESP_OKAY)
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) smem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                have_aw = 0; have_w = 0; b_arm = 1; b_cnt = 0;
            end
            if (b_arm) begin
                if (b_cnt >= b_dly) begin
                    bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = s_bresp; b_arm = 0;
                end else b_cnt++;
            end
            if (r_arm) begin
                if (r_cnt >= r_dly) begin
                    er = slave_rule(s_araddr);
                    bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RRESP = er;
                    bus.M_AXI_RDATA  = (er == RESP_OKAY) ? smem[s_araddr[5:2]] : 32'h0;
                    r_arm = 0;
                end else r_cnt++;
            end
            bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && !have_aw && (aw_cnt >= aw_dly);
            if (bus.M_AXI_AWVALID && !have_aw && !bus.M_AXI_AWREADY) aw_cnt++;
            bus.M_AXI_WREADY = bus.M_AXI_WVALID && !have_w && (w_cnt >= w_dly);
            if (bus.M_AXI_WVALID && !have_w && !bus.M_AXI_WREADY) w_cnt++;
            bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (ar_cnt >= ar_dly);
            if (bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY) ar_cnt++;
            if (bus.M_AXI_AWVALID && !bus.M_AXI_WVALID) aw_only++;
            // Everything seen now is frozen until the next posedge.
            pv_aw = bus.M_AXI_AWVALID; l_awaddr = bus.M_AXI_AWADDR;
            pv_w  = bus.M_AXI_WVALID;  l_wdata = bus.M_AXI_WDATA; l_wstrb = bus.M_AXI_WSTRB;
            pv_ar = bus.M_AXI_ARVALID; l_araddr = bus.M_AXI_ARADDR;
            hs_aw = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
            hs_w  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
            hs_b  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
            hs_ar = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
            hs_r  = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
        end
    end

    // ---------------- reference model + command driver ----------------
    logic [31:0] mem_ref [16];
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic        exp_write;
    int          acc_cyc = 0, n_writes = 0;
    logic        s_aw, s_w, s_ar, s_cr, s_busy;

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int waits);
        bit ok = 0;
        waits = 0;
        bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_wstrb = s;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.cmd_ready) begin ok = 1; break; end
            waits++;
            @(negedge clk);
        end
        if (!ok) begin
            chk("cmd_accept_bound", 32'(ok), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        exp_write = w;
        exp_resp  = slave_rule(a);
        if (w) begin
            exp_data = 32'h0;
            n_writes++;
            if (exp_resp == RESP_OKAY)
                for (int b = 0; b < 4; b++)
                    if (s[b]) mem_ref[a[5:2]][8*b +: 8] = d[8*b +: 8];
        end else begin
            exp_data = (exp_resp == RESP_OKAY) ? mem_ref[a[5:2]] : 32'h0;
        end
        @(negedge clk);
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
        s_aw = bus.M_AXI_AWVALID; s_w = bus.M_AXI_WVALID; s_ar = bus.M_AXI_ARVALID;
        s_cr = bus.cmd_ready; s_busy = busy;
    endtask

    // Latency counts cycles from acceptance: the first cycle after the accept
    // edge is 1.
    task automatic get_rsp(input string tag, input bit check_lat, input int exp_lat);
        bit ok = 0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.rsp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk({tag, "_rsp_bound"}, 32'(ok), 32'd1);
            bus.rsp_ready = 1'b0;
            return;
        end
        if (check_lat) chk({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(exp_lat));
        chk({tag, "_rsp_data"},  bus.rsp_data, exp_data);
        chk({tag, "_rsp_resp"},  32'(bus.rsp_resp), 32'(exp_resp));
        chk({tag, "_rsp_write"}, 32'(bus.rsp_write), 32'(exp_write));
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin : main
        int          waits, b0;
        bit          ok, stable, crz, early;
        logic [31:0] d0;
        logic [1:0]  r0;
        logic        w0;
        logic        rw;
        logic [31:0] ra;

        for (int i = 0; i < 16; i++) mem_ref[i] = 32'h0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0;
        bus.cmd_wdata = 32'h0; bus.cmd_wstrb = 4'h0; bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_valid_ready", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                    bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.rsp_valid}), 32'd0);
        chk("rst_busy_timeout", 32'({busy, timeout}), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_rsp_resp_write", 32'({bus.rsp_resp, bus.rsp_write}), 32'd0);
        @(negedge clk);

        // Write run=1 to the CTRL register, slave ready on AW and W at once
        send_cmd(1'b1, REG_CTRL, 32'h0000_0002, 4'hF, waits);
        chk("t1_awvalid_n1", 32'(s_aw), 32'd1);
        chk("t1_wvalid_n1", 32'(s_w), 32'd1);
        chk("t1_busy_cmdready", 32'({s_busy, s_cr}), 32'b10);
        get_rsp("t1", 1'b1, 3);
        chk("t1_run_bit", 32'(smem[0][1]), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // AWREADY lags WREADY by four cycles
        aw_dly = 4; b0 = b_hs_count; aw_only = 0;
        send_cmd(1'b1, 32'h0000_0008, 32'h1234_5678, 4'hF, waits);
        get_rsp("t2", 1'b1, 7);
        chk("t2_aw_only_cycles", 32'(aw_only), 32'd4);
        chk("t2_b_handshakes", 32'(b_hs_count - b0), 32'd1);
        chk("t2_smem", smem[2], 32'h1234_5678);
        aw_dly = 0;

        // Write then read back the control register
        send_cmd(1'b1, REG_CONTROL, 32'hDEAD_BEEF, 4'hF, waits);
        get_rsp("t3w", 1'b0, 0);
        send_cmd(1'b0, REG_CONTROL, 32'h0, 4'h0, waits);
        get_rsp("t3r", 1'b1, 3);

        // Response back-pressure with the next command already waiting
        send_cmd(1'b0, REG_CONTROL, 32'h0, 4'h0, waits);
        bus.cmd_write = 1'b1; bus.cmd_addr = 32'h0000_0004;
        bus.cmd_wdata = 32'hA5A5_0F0F; bus.cmd_wstrb = 4'b0101;
        bus.cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.rsp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("t4_rsp_seen", 32'(ok), 32'd1);
        d0 = bus.rsp_data; r0 = bus.rsp_resp; w0 = bus.rsp_write;
        stable = 1; crz = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.rsp_resp !== r0 || bus.rsp_write !== w0)
                stable = 0;
            if (bus.cmd_ready !== 1'b0) crz = 0;
        end
        chk("t4_rsp_data", d0, 32'hDEAD_BEEF);
        chk("t4_rsp_resp_write", 32'({r0, w0}), 32'd0);
        chk("t4_rsp_stable", 32'(stable), 32'd1);
        chk("t4_cmd_ready_low", 32'(crz), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("t4_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
        send_cmd(1'b1, 32'h0000_0004, 32'hA5A5_0F0F, 4'b0101, waits);
        chk("t4_next_accept_waits", 32'(waits), 32'd0);
        get_rsp("t4n", 1'b0, 0);

        // Randomized commands with random slave stalls
        for (int n = 0; n < 40; n++) begin
            aw_dly = $urandom_range(2); w_dly = $urandom_range(2); b_dly = $urandom_range(2);
            ar_dly = $urandom_range(2); r_dly = $urandom_range(2);
            rw = 1'($urandom_range(1));
            ra = {26'd0, 4'($urandom_range(15)), 2'b00};
            send_cmd(rw, ra, $urandom, 4'($urandom_range(15)), waits);
            get_rsp("rnd", 1'b0, 0);
        end
        {aw_dly, w_dly, b_dly, ar_dly, r_dly} = '0;

        // Error responses are forwarded untouched
        send_cmd(1'b1, 32'h0000_003C, 32'h1111_2222, 4'hF, waits);
        get_rsp("t6_slverr", 1'b1, 3);
        chk("t6_resp_code", 32'(exp_resp), 32'(RESP_SLVERR));
        send_cmd(1'b0, 32'h1000_0000, 32'h0, 4'h0, waits);
        get_rsp("t6_decerr", 1'b0, 0);
        chk("t6_timeout_low", 32'(timeout), 32'd0);
        chk("prot_violations", 32'(prot_err), 32'd0);
        chk("b_handshake_count", 32'(b_hs_count), 32'(n_writes));

        // Slave never takes AR: timeout after 8 waiting cycles, then reset
        ar_dly = 1_000_000;
        send_cmd(1'b0, REG_CONTROL, 32'h0, 4'h0, waits);
        early = 0;
        for (int r = 1; r <= 8; r++) begin
            if (timeout !== 1'b0) early = 1;
            @(negedge clk);
        end
        chk("t7_timeout_early", 32'(early), 32'd0);
        chk("t7_timeout_cycle9", 32'(timeout), 32'd1);
        chk("t7_arvalid_held", 32'(bus.M_AXI_ARVALID), 32'd1);
        repeat (3) @(negedge clk);
        chk("t7_sticky", 32'({timeout, bus.M_AXI_ARVALID}), 32'b11);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ar_dly = 0;
        chk("t7_rst_arvalid", 32'(bus.M_AXI_ARVALID), 32'd0);
        chk("t7_rst_timeout", 32'(timeout), 32'd0);
        chk("t7_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        send_cmd(1'b0, REG_CONTROL, 32'h0, 4'h0, waits);
        get_rsp("t7_recover", 1'b1, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI4-Lite master that turns single-beat register commands into AXI-Lite write or read transactions and returns one response per command. It is the initiator side of the control/status register slave in the accelerator top-level. It lets an on-chip sequencer or a bench drive `{last, run, matw}` at offset 0x00 and `control` at 0x10, and poll them, without hand-writing AXI handshakes.

## Interface
- `TIMEOUT`, default 1024: cycles a transaction may wait on the slave before `timeout` is flagged; 0 disables the check.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address, passed through unchanged.
- `cmd_wdata`  in  32  write data.
- `cmd_wstrb`  in  4  write byte strobes.
- `rsp_valid` / `rsp_ready`  out/in  1  response handshake.
- `rsp_data`  out  32  read data (0 for writes).
- `rsp_resp`  out  2  BRESP or RRESP as received.
- `rsp_write`  out  1  echoes `cmd_write` of the completed command.
- `busy`  out  1  high from command acceptance until the response is consumed.
- `timeout`  out  1  sticky; set when a transaction exceeds `TIMEOUT`; cleared only by `rst`.
- `M_AXI_AW{ADDR[31:0],VALID,READY}`, `M_AXI_W{DATA[31:0],STRB[3:0],VALID,READY}`, `M_AXI_B{RESP[1:0],VALID,READY}`, `M_AXI_AR{ADDR[31:0],VALID,READY}`, `M_AXI_R{DATA[31:0],RESP[1:0],VALID,READY}`: standard AXI4-Lite master channels; `*PROT` is tied to 3'b000.

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch addr/wdata/wstrb/write and go to WRITE (write) or RADDR (read).
- WRITE: raise AWVALID and WVALID together. Each channel drops independently on its own READY. Both handshakes may complete in the same cycle or in either order. Go to WRESP once both are done.
- WRESP: BREADY=1. On BVALID, capture BRESP, set `rsp_data`=0, go to RSP.
- RADDR: ARVALID=1 until ARREADY, then go to RDATA.
- RDATA: RREADY=1. On RVALID, capture RDATA/RRESP, go to RSP.
- RSP: `rsp_valid`=1 and the captured fields are held stable until `rsp_ready`, then return to IDLE.
- Only one command is outstanding at a time. `cmd_ready` is 0 in every state except IDLE.
- Address, data and strobe outputs are stable while their VALID is high. VALID never drops before READY.
- Timeout counter:
  - Clears on command acceptance and counts in WRITE/WRESP/RADDR/RDATA.
  - When it reaches `TIMEOUT`, `timeout` is set.
  - The transaction is NOT aborted: the block keeps waiting, because dropping VALID is illegal.
  - The counter saturates.
- `rst` in any state returns to IDLE, drops all VALID/READY outputs and clears `timeout`. The in-flight response is lost. The slave must be reset in the same cycle.

## Timing
- Reset values: all VALID/READY outputs 0, `busy` 0, `timeout` 0, `rsp_data` 0, `rsp_resp` 0, `rsp_write` 0. `cmd_ready` reads 1 in the first cycle after reset.
- All outputs are registered or decoded directly from state; there is no combinational path from any input to any output.
- Command accepted at edge N:
  - VALIDs high from cycle N+1.
  - Minimum write latency to `rsp_valid` is 3 cycles (AW/W at N+1, B at N+2, RSP at N+3).
  - Minimum read latency is 3 cycles.
- BREADY/RREADY are asserted only in WRESP/RDATA. A BVALID or RVALID arriving earlier is held by the slave, per protocol.
- A new command can be accepted the cycle after the `rsp_ready` handshake, so the peak rate is 1 command per 4 cycles.

## Structure
- Shared package `axil_pkg`:
  - state enum,
  - response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11,
  - register offsets `REG_CTRL`=0x00 and `REG_CONTROL`=0x10.
- Single flat module; no sub-module. The timeout counter is inline.

## Test plan
- Write 0x00 ← 0x0000_0002 with a slave that accepts AW+W together → AWVALID/WVALID rise at N+1, `rsp_valid` at N+3, `rsp_resp`=00, `rsp_write`=1; slave reads back run=1.
- Write with AWREADY delayed 4 cycles after WREADY → WVALID drops after its handshake, AWVALID stays high until AWREADY, exactly one BREADY handshake occurs.
- Read 0x10 after writing 0xDEAD_BEEF there → `rsp_data`=0xDEADBEEF, `rsp_resp`=00, `rsp_write`=0.
- Hold `rsp_ready`=0 for 10 cycles with `cmd_valid` held high → `rsp_*` stable, `cmd_ready`=0 throughout, the next command is accepted exactly one cycle after the response handshake.
- `TIMEOUT`=8, slave never asserts ARREADY → `timeout` rises at cycle 9 and ARVALID stays high. Then pulse `rst` → ARVALID=0, `timeout`=0, `cmd_ready`=1.
- Slave returns BRESP=2'b10 → `rsp_resp`=2'b10 is forwarded and `timeout` stays 0.
